// File: rtl/wishbone_to_axi4l_pkg.sv
// wishbone_to_axi4l_pkg: shared FSM states and AXI4-Lite response codes for the bridge
package wishbone_to_axi4l_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ACK} state_t;
  localparam logic [1:0] AXI4L_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4L_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI4L_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI4L_RESP_DECERR = 2'b11;
  function automatic logic resp_err(input logic [1:0] r);
    return r != AXI4L_RESP_OKAY;
  endfunction
endpackage

// File: rtl/wishbone_to_axi4l_master.sv
// wishbone_to_axi4l_master: Wishbone classic slave issuing one AXI4-Lite master transaction per access
module wishbone_to_axi4l_master
  import wishbone_to_axi4l_pkg::*;
#(
  parameter int WB_ADR_BITS = 37,
  parameter int WB_DAT_BITS = 64,
  parameter int WB_SEL_BITS = WB_DAT_BITS / 8,
  parameter int AXI4L_ADDR_BITS = 40,
  parameter logic [2:0] AXI4L_PROT = 3'b000
) (
  input  logic                       m_axi4l_aclk,
  input  logic                       m_axi4l_aresetn,
  input  logic [WB_ADR_BITS-1:0]     s_wb_adr_i,
  input  logic [WB_DAT_BITS-1:0]     s_wb_dat_i,
  output logic [WB_DAT_BITS-1:0]     s_wb_dat_o,
  input  logic [WB_SEL_BITS-1:0]     s_wb_sel_i,
  input  logic                       s_wb_we_i,
  input  logic                       s_wb_stb_i,
  output logic                       s_wb_ack_o,
  output logic                       s_wb_err_o,
  output logic                       err_sticky,
  output logic [AXI4L_ADDR_BITS-1:0] m_axi4l_awaddr,
  output logic [2:0]                 m_axi4l_awprot,
  output logic                       m_axi4l_awvalid,
  input  logic                       m_axi4l_awready,
  output logic [WB_DAT_BITS-1:0]     m_axi4l_wdata,
  output logic [WB_SEL_BITS-1:0]     m_axi4l_wstrb,
  output logic                       m_axi4l_wvalid,
  input  logic                       m_axi4l_wready,
  input  logic [1:0]                 m_axi4l_bresp,
  input  logic                       m_axi4l_bvalid,
  output logic                       m_axi4l_bready,
  output logic [AXI4L_ADDR_BITS-1:0] m_axi4l_araddr,
  output logic [2:0]                 m_axi4l_arprot,
  output logic                       m_axi4l_arvalid,
  input  logic                       m_axi4l_arready,
  input  logic [WB_DAT_BITS-1:0]     m_axi4l_rdata,
  input  logic [1:0]                 m_axi4l_rresp,
  input  logic                       m_axi4l_rvalid,
  output logic                       m_axi4l_rready
);
  localparam int OFS = $clog2(WB_SEL_BITS);
  state_t state_q, state_d;
  logic [AXI4L_ADDR_BITS-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d, axi_adr;
  logic [WB_ADR_BITS+OFS-1:0] byte_adr;
  logic [WB_DAT_BITS-1:0] wdata_q, wdata_d, dat_q, dat_d;
  logic [WB_SEL_BITS-1:0] wstrb_q, wstrb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic ack_q, ack_d, err_q, err_d, sticky_q, sticky_d;
  logic aw_done, w_done, fin;
  logic [1:0] resp;
  assign byte_adr = (WB_ADR_BITS+OFS)'(s_wb_adr_i) << OFS;
  assign axi_adr = AXI4L_ADDR_BITS'(byte_adr);
  // a channel counts as done once its valid has dropped or is being accepted this edge
  assign aw_done = ~awvalid_q | m_axi4l_awready;
  assign w_done = ~wvalid_q | m_axi4l_wready;
  assign fin = (state_q == WR_RESP && m_axi4l_bvalid) || (state_q == RD_RESP && m_axi4l_rvalid);
  assign resp = state_q == WR_RESP ? m_axi4l_bresp : m_axi4l_rresp;
  always_comb begin
    state_d = state_q;
    awaddr_d = awaddr_q;
    araddr_d = araddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    dat_d = dat_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    bready_d = bready_q;
    arvalid_d = arvalid_q;
    rready_d = rready_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: if (s_wb_stb_i) begin
        state_d = s_wb_we_i ? WR_REQ : RD_REQ;
        awvalid_d = s_wb_we_i;
        wvalid_d = s_wb_we_i;
        arvalid_d = ~s_wb_we_i;
        awaddr_d = s_wb_we_i ? axi_adr : awaddr_q;
        wdata_d = s_wb_we_i ? s_wb_dat_i : wdata_q;
        wstrb_d = s_wb_we_i ? s_wb_sel_i : wstrb_q;
        araddr_d = s_wb_we_i ? araddr_q : axi_adr;
      end
      WR_REQ: begin
        awvalid_d = ~aw_done;
        wvalid_d = ~w_done;
        if (aw_done && w_done) begin
          state_d = WR_RESP;
          bready_d = 1'b1;
        end
      end
      RD_REQ: if (m_axi4l_arready) begin
        arvalid_d = 1'b0;
        rready_d = 1'b1;
        state_d = RD_RESP;
      end
      RD_RESP: dat_d = m_axi4l_rvalid ? m_axi4l_rdata : dat_q;
      ACK: state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (fin) begin
      state_d = ACK;
      bready_d = 1'b0;
      rready_d = 1'b0;
      ack_d = 1'b1;
      err_d = resp_err(resp);
      sticky_d = sticky_q | err_d;
    end
  end
  always_ff @(posedge m_axi4l_aclk) begin
    if (!m_axi4l_aresetn) begin
      state_q <= IDLE;
      awaddr_q <= '0;
      araddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      dat_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      awaddr_q <= awaddr_d;
      araddr_q <= araddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      dat_q <= dat_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
      ack_q <= ack_d;
      err_q <= err_d;
      sticky_q <= sticky_d;
    end
  end
  assign s_wb_dat_o = dat_q;
  assign s_wb_ack_o = ack_q;
  assign s_wb_err_o = err_q;
  assign err_sticky = sticky_q;
  assign m_axi4l_awaddr = awaddr_q;
  assign m_axi4l_awprot = AXI4L_PROT;
  assign m_axi4l_awvalid = awvalid_q;
  assign m_axi4l_wdata = wdata_q;
  assign m_axi4l_wstrb = wstrb_q;
  assign m_axi4l_wvalid = wvalid_q;
  assign m_axi4l_bready = bready_q;
  assign m_axi4l_araddr = araddr_q;
  assign m_axi4l_arprot = AXI4L_PROT;
  assign m_axi4l_arvalid = arvalid_q;
  assign m_axi4l_rready = rready_q;
endmodule

// File: tb/tb_wishbone_to_axi4l_master.sv
// tb_wishbone_to_axi4l_master: directed Wishbone accesses against a delay-configurable AXI4-Lite slave, checked by a transaction model
module tb_wishbone_to_axi4l_master;
  logic clk = 1'b0, rstn = 1'b0;
  logic [36:0] adr = '0;
  logic [63:0] wdat = '0, dat_o, wdata, rdata = '0;
  logic [7:0] sel = '0, wstrb;
  logic we = 1'b0, stb = 1'b0, ack, err, sticky;
  logic [39:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [1:0] bresp = '0, rresp = '0;

  wishbone_to_axi4l_master dut (
    .m_axi4l_aclk(clk), .m_axi4l_aresetn(rstn),
    .s_wb_adr_i(adr), .s_wb_dat_i(wdat), .s_wb_dat_o(dat_o), .s_wb_sel_i(sel),
    .s_wb_we_i(we), .s_wb_stb_i(stb), .s_wb_ack_o(ack), .s_wb_err_o(err), .err_sticky(sticky),
    .m_axi4l_awaddr(awaddr), .m_axi4l_awprot(awprot), .m_axi4l_awvalid(awvalid), .m_axi4l_awready(awready),
    .m_axi4l_wdata(wdata), .m_axi4l_wstrb(wstrb), .m_axi4l_wvalid(wvalid), .m_axi4l_wready(wready),
    .m_axi4l_bresp(bresp), .m_axi4l_bvalid(bvalid), .m_axi4l_bready(bready),
    .m_axi4l_araddr(araddr), .m_axi4l_arprot(arprot), .m_axi4l_arvalid(arvalid), .m_axi4l_arready(arready),
    .m_axi4l_rdata(rdata), .m_axi4l_rresp(rresp), .m_axi4l_rvalid(rvalid), .m_axi4l_rready(rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [63:0] rdata_cfg = '0;

  typedef struct {
    bit we;
    logic [36:0] adr;
    logic [63:0] dat;
    logic [7:0] sel;
    logic [1:0] resp;
    logic [63:0] rdata;
  } txn_t;
  txn_t q[$];
  txn_t e;
  logic [63:0] last_rd = '0;
  logic sticky_m = 1'b0, rstn_prev = 1'b0;
  logic [39:0] exp_a;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  int aw_total = 0, w_total = 0, ack_total = 0;
  logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic p_br = 0, p_bv = 0, p_rr = 0, p_rv = 0, p_ack = 0;
  logic [39:0] p_awaddr = '0, p_araddr = '0;
  logic [63:0] p_wdata = '0;
  logic [7:0] p_wstrb = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // AXI4-Lite slave: each channel answers after its configured number of cycles
  initial forever begin
    @(posedge clk); #1;
    if (!rstn) begin awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; end
    else begin
      if (awvalid && !awready) begin if (aw_c == aw_dly) awready = 1; else aw_c++; end
      else begin awready = 0; aw_c = 0; end
      if (wvalid && !wready) begin if (w_c == w_dly) wready = 1; else w_c++; end
      else begin wready = 0; w_c = 0; end
      if (arvalid && !arready) begin if (ar_c == ar_dly) arready = 1; else ar_c++; end
      else begin arready = 0; ar_c = 0; end
      if (bready && !bvalid) begin if (b_c == b_dly) begin bvalid = 1; bresp = bresp_cfg; end else b_c++; end
      else begin bvalid = 0; b_c = 0; end
      if (rready && !rvalid) begin if (r_c == r_dly) begin rvalid = 1; rresp = rresp_cfg; rdata = rdata_cfg; end else r_c++; end
      else begin rvalid = 0; r_c = 0; end
    end
  end

  // Model compare: every cycle, DUT outputs against the transaction queue and protocol rules
  always @(negedge clk) begin
    if (!rstn_prev) begin
      chk("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, ack, err, sticky}, 0);
      chk("rst_dat", dat_o, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_addr", {awaddr, wstrb}, 0);
      chk("rst_araddr", araddr, 0);
      q.delete();
      sticky_m = 0; last_rd = '0;
      n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    end else begin
      if (q.size() == 0) chk("idle_quiet", {awvalid, wvalid, bready, arvalid, rready, ack}, 0);
      else begin
        e = q[0];
        exp_a = {3'b000, e.adr} * 40'd8;
        if (awvalid) chk("awaddr", awaddr, exp_a);
        if (wvalid) chk("wdata", wdata, e.dat);
        if (wvalid) chk("wstrb", wstrb, e.sel);
        if (arvalid) chk("araddr", araddr, exp_a);
        if (awvalid || wvalid || bready) chk("wr_kind", e.we, 1);
        if (arvalid || rready) chk("rd_kind", e.we, 0);
        if (ack) begin
          chk("hs_counts", {n_aw[7:0], n_w[7:0], n_b[7:0], n_ar[7:0], n_r[7:0]},
              e.we ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01);
          if (!e.we) last_rd = e.rdata;
          sticky_m = sticky_m | (e.resp != 2'b00);
          chk("err_at_ack", err, e.resp != 2'b00);
          void'(q.pop_front());
          n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
          ack_total++;
        end
      end
      if (!ack) chk("err_idle", err, 0);
      if (p_ack) chk("ack_pulse", ack, 0);
      chk("dat_o", dat_o, last_rd);
      chk("sticky", sticky, sticky_m);
      chk("prot", {awprot, arprot}, 0);
      if (p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_awv && p_awr) chk("aw_drop", awvalid, 0);
      if (p_wv && !p_wr) chk("w_hold", {wvalid, wstrb}, {1'b1, p_wstrb});
      if (p_wv && !p_wr) chk("w_hold_data", wdata, p_wdata);
      if (p_wv && p_wr) chk("w_drop", wvalid, 0);
      if (p_arv && !p_arr) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
      if (p_arv && p_arr) chk("ar_drop", arvalid, 0);
      if (p_br && !p_bv) chk("b_hold", bready, 1);
      if (p_rr && !p_rv) chk("r_hold", rready, 1);
      if (awvalid && awready) begin n_aw++; aw_total++; end
      if (wvalid && wready) begin n_w++; w_total++; end
      if (bvalid && bready) n_b++;
      if (arvalid && arready) n_ar++;
      if (rvalid && rready) n_r++;
    end
    p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready; p_arv = arvalid; p_arr = arready;
    p_br = bready; p_bv = bvalid; p_rr = rready; p_rv = rvalid; p_ack = ack;
    p_awaddr = awaddr; p_araddr = araddr; p_wdata = wdata; p_wstrb = wstrb;
    rstn_prev = rstn;
  end

  // Issue one access starting at posedge+1; returns cycles from stb-sampled cycle to ack
  task automatic wb(input bit w, input logic [36:0] a, input logic [63:0] d, input logic [7:0] s,
                    input bit keep, output int lat, output logic e_err, output logic [63:0] e_dat);
    q.push_back('{w, a, d, s, w ? bresp_cfg : rresp_cfg, rdata_cfg});
    stb = 1; we = w; adr = a; wdat = d; sel = s;
    lat = 0;
    @(negedge clk);
    while (!ack && lat < 100) begin lat++; @(negedge clk); end
    chk("ack_seen", ack, 1);
    e_err = err; e_dat = dat_o;
    @(posedge clk); #1;
    if (!keep) stb = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int lat, a0, w0, k0, wait_c;
  logic e_err;
  logic [63:0] e_dat;
  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(posedge clk); #1;
    // immediate-ready write
    wb(1, 37'h10, 64'h1122334455667788, 8'hFF, 0, lat, e_err, e_dat);
    chk("t1_lat", lat, 3);
    chk("t1_err", e_err, 0);
    chk("t1_awaddr", awaddr, 40'h80);
    chk("t1_wstrb", wstrb, 8'hFF);
    // read with rvalid delayed 5 cycles
    r_dly = 5; rdata_cfg = 64'hDEADBEEF;
    wb(0, 37'h3, '0, 8'hFF, 0, lat, e_err, e_dat);
    chk("t2_lat", lat, 8);
    chk("t2_araddr", araddr, 40'h18);
    chk("t2_dat", e_dat, 64'hDEADBEEF);
    r_dly = 0;
    // W accepted 4 cycles before AW
    aw_dly = 4;
    wb(1, 37'h1F, 64'hA5A5_5A5A_0F0F_F0F0, 8'h0F, 0, lat, e_err, e_dat);
    chk("t3_lat", lat, 7);
    chk("t3_dat_kept", dat_o, 64'hDEADBEEF);
    aw_dly = 0;
    // SLVERR read, then OKAY write with zero strobes
    rresp_cfg = 2'b10; rdata_cfg = 64'h0123_4567_89AB_CDEF;
    wb(0, 37'h40, '0, 8'hFF, 0, lat, e_err, e_dat);
    chk("t4_err", e_err, 1);
    chk("t4_dat", e_dat, 64'h0123_4567_89AB_CDEF);
    chk("t4_sticky", sticky, 1);
    rresp_cfg = 2'b00;
    wb(1, 37'h41, 64'h55, 8'h00, 0, lat, e_err, e_dat);
    chk("t4_ok_err", e_err, 0);
    chk("t4_sticky_kept", sticky, 1);
    chk("t4_wstrb0", wstrb, 8'h00);
    // back-to-back writes with stb held high, including the top word address
    a0 = aw_total; w0 = w_total; k0 = ack_total;
    wb(1, 37'h1F_FFFF_FFFF, 64'h1, 8'h01, 1, lat, e_err, e_dat);
    chk("t5_lat0", lat, 3);
    wb(1, 37'h2, 64'h2, 8'h03, 1, lat, e_err, e_dat);
    chk("t5_lat1", lat, 3);
    wb(1, 37'h3, 64'h3, 8'h07, 0, lat, e_err, e_dat);
    chk("t5_lat2", lat, 3);
    chk("t5_awaddr_top", awaddr, 40'h18);
    chk("t5_counts", {8'(aw_total - a0), 8'(w_total - w0), 8'(ack_total - k0)}, 24'h03_03_03);
    // reset while waiting for the write response
    b_dly = 20;
    q.push_back('{1'b1, 37'h7, 64'h77, 8'hFF, 2'b00, 64'h0});
    stb = 1; we = 1; adr = 37'h7; wdat = 64'h77; sel = 8'hFF;
    wait_c = 0;
    @(negedge clk);
    while (!bready && wait_c < 50) begin wait_c++; @(negedge clk); end
    chk("t6_bready_up", bready, 1);
    @(posedge clk); #1;
    stb = 0; rstn = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_bready_rst", bready, 0);
    chk("t6_ack_rst", ack, 0);
    @(posedge clk); #1;
    rstn = 1; b_dly = 0;
    @(posedge clk); #1;
    rdata_cfg = 64'hFEED_F00D;
    wb(0, 37'h5, '0, 8'hFF, 0, lat, e_err, e_dat);
    chk("t6_lat", lat, 3);
    chk("t6_dat", e_dat, 64'hFEED_F00D);
    chk("t6_araddr", araddr, 40'h28);
    repeat (3) @(posedge clk);
    chk("q_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
